// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: FIFO of fetched {pc, instr} pairs between IF and ID, flushed by a taken branch
// Ports: clk, rst (async active-low); in_valid/in_pc/in_instr/in_ready push side (freeze = ~in_ready);
// flush clears the queue; out_valid/out_pc/out_instr/out_ready first-word fall-through head; count = occupancy.
module if_prefetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [WIDTH-1:0] in_instr,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_pc,
  output logic [WIDTH-1:0] out_instr,
  input  logic             out_ready,
  output logic [PTR_W:0]   count
);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
  logic [WIDTH-1:0] pc_mem [DEPTH];
  logic [WIDTH-1:0] instr_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push, pop;
  assign in_ready  = count != FULL;
  assign out_valid = count != '0;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  // empty queue presents zeros so ID sees a NOP
  assign out_pc    = out_valid ? pc_mem[rd_ptr] : '0;
  assign out_instr = out_valid ? instr_mem[rd_ptr] : '0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count  <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= in_instr;
    end
  end
endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb_if_prefetch_queue: randomized and directed checks of if_prefetch_queue against a queue model
module tb_if_prefetch_queue;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;
  localparam int WIDTH = 32;
  logic             clk = 0;
  logic             rst = 0;
  logic             in_valid = 0;
  logic [WIDTH-1:0] in_pc = 0;
  logic [WIDTH-1:0] in_instr = 0;
  logic             in_ready;
  logic             flush = 0;
  logic             out_valid;
  logic [WIDTH-1:0] out_pc;
  logic [WIDTH-1:0] out_instr;
  logic             out_ready = 0;
  logic [PTR_W:0]   count;
  int vectors = 0;
  int errors = 0;
  logic [63:0] q[$];
  if_prefetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_pc(out_pc),
    .out_instr(out_instr), .out_ready(out_ready), .count(count)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] m_pc();
    return q.size() != 0 ? q[0][63:32] : 32'd0;
  endfunction
  function automatic logic [31:0] m_instr();
    return q.size() != 0 ? q[0][31:0] : 32'd0;
  endfunction
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins, input logic rdy, input logic fl);
    in_valid = v;
    in_pc = pc;
    in_instr = ins;
    out_ready = rdy;
    flush = fl;
    #1;
  endtask
  task automatic tick();
    bit do_push, do_pop;
    do_push = in_valid && q.size() < DEPTH && !flush;
    do_pop  = q.size() > 0 && out_ready && !flush;
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back({in_pc, in_instr});
    end
    #1;
  endtask
  task automatic test_reset();
    #8;
    vectors++;
    if ({out_valid, out_pc, out_instr, in_ready, count} !== {1'b0, 32'd0, 32'd0, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL reset_during: valid=%0b pc=%h instr=%h ready=%0b count=%0d want 0/0/0/1/0", out_valid, out_pc, out_instr, in_ready, count);
    end
    #9 rst = 1;
    @(posedge clk);
    #1;
    vectors++;
    if ({out_valid, out_pc, out_instr, in_ready, count} !== {1'b0, 32'd0, 32'd0, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL reset_after: valid=%0b pc=%h instr=%h ready=%0b count=%0d want 0/0/0/1/0", out_valid, out_pc, out_instr, in_ready, count);
    end
  endtask
  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'(4 * (i + 1)), 32'hE3A00001 + 32'(i), 0, 0);
      vectors++;
      if (in_ready !== 1'b1 || count !== 3'(i)) begin
        errors++;
        $display("FAIL fill_%0d: ready=%0b count=%0d want 1/%0d", i, in_ready, count, i);
      end
      tick();
    end
    drive(1, 32'd20, 32'hE3A00005, 0, 0);
    vectors++;
    if (count !== 3'd4 || in_ready !== 1'b0 || out_pc !== 32'd4 || out_instr !== 32'hE3A00001) begin
      errors++;
      $display("FAIL fill_full: count=%0d ready=%0b pc=%h instr=%h want 4/0/4/e3a00001", count, in_ready, out_pc, out_instr);
    end
    tick();
    vectors++;
    if (count !== 3'd4 || out_pc !== 32'd4 || q.size() != 4) begin
      errors++;
      $display("FAIL fill_reject: count=%0d pc=%h want 4/4", count, out_pc);
    end
  endtask
  task automatic test_drain_wrap();
    logic [31:0] exp_pc[6];
    logic [31:0] pc;
    exp_pc = '{32'd4, 32'd8, 32'd12, 32'd16, 32'd20, 32'd24};
    pc = 20;
    for (int k = 0; k < 6; k++) begin
      drive(1, pc, 32'hE3A00000 + pc, 1, 0);
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc[k] || count > 3'd4) begin
        errors++;
        $display("FAIL drain_%0d: valid=%0b pc=%h count=%0d want 1/%h/<=4", k, out_valid, out_pc, count, exp_pc[k]);
      end
      vectors++;
      if (in_ready !== (k != 0)) begin
        errors++;
        $display("FAIL drain_ready_%0d: ready=%0b want %0b", k, in_ready, k != 0);
      end
      if (in_ready) pc += 4;
      tick();
    end
  endtask
  task automatic test_simul();
    logic [31:0] pc;
    drive(0, 0, 0, 1, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      pc = $urandom;
      drive(1, pc, $urandom, 1, 0);
      vectors++;
      if (count !== 3'd2 || out_pc !== m_pc() || out_instr !== m_instr()) begin
        errors++;
        $display("FAIL simul_%0d: count=%0d pc=%h instr=%h want 2/%h/%h", i, count, out_pc, out_instr, m_pc(), m_instr());
      end
      tick();
    end
    for (int i = 0; i < 8 && q.size() != 0; i++) begin
      drive(0, 0, 0, 1, 0);
      tick();
    end
    drive(1, 32'h200, 32'hE3A00200, 1, 0);
    vectors++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL empty_passthru_same: valid=%0b count=%0d want 0/0", out_valid, count);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_pc !== 32'h200) begin
      errors++;
      $display("FAIL empty_passthru_next: valid=%0b pc=%h want 1/200", out_valid, out_pc);
    end
  endtask
  task automatic test_flush();
    drive(1, 32'h204, 32'h1, 0, 0);
    tick();
    drive(1, 32'h208, 32'h2, 0, 0);
    tick();
    vectors++;
    if (count !== 3'd3) begin
      errors++;
      $display("FAIL flush_pre: count=%0d want 3", count);
    end
    drive(1, 32'h40, 32'hE3A00040, 1, 1);
    tick();
    vectors++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_instr !== 32'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_post: count=%0d valid=%0b instr=%h ready=%0b want 0/0/0/1", count, out_valid, out_instr, in_ready);
    end
    drive(1, 32'h100, 32'hE3A00100, 0, 0);
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_pc !== 32'h100) begin
      errors++;
      $display("FAIL flush_next_head: valid=%0b pc=%h want 1/100", out_valid, out_pc);
    end
  endtask
  task automatic test_reset_mid();
    drive(1, 32'h104, 32'h4, 0, 0);
    tick();
    drive(1, 32'h108, 32'h8, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    vectors++;
    if (count !== 3'd3) begin
      errors++;
      $display("FAIL reset_mid_pre: count=%0d want 3", count);
    end
    #2 rst = 0;
    #1;
    q.delete();
    vectors++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_pc !== 32'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_async: count=%0d valid=%0b pc=%h ready=%0b want 0/0/0/1", count, out_valid, out_pc, in_ready);
    end
    #2 rst = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h300 + 32'(4 * i), $urandom, 0, 0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 0);
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== 32'h300 + 32'(4 * i) || out_instr !== m_instr()) begin
        errors++;
        $display("FAIL reset_mid_resume_%0d: valid=%0b pc=%h want 1/%h", i, out_valid, out_pc, 32'h300 + 32'(4 * i));
      end
      tick();
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
      vectors++;
      if (out_valid !== (q.size() != 0) || in_ready !== (q.size() != DEPTH) || count !== 3'(q.size())
          || out_pc !== m_pc() || out_instr !== m_instr()) begin
        errors++;
        $display("FAIL random_%0d: valid=%0b ready=%0b count=%0d pc=%h instr=%h want %0b/%0b/%0d/%h/%h",
                 i, out_valid, in_ready, count, out_pc, out_instr, q.size() != 0, q.size() != DEPTH, q.size(), m_pc(), m_instr());
      end
      tick();
    end
  endtask
  initial begin
    test_reset();
    test_fill();
    test_drain_wrap();
    test_simul();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
